// File: rtl/quant_ctrl.sv
// quant_ctrl: parameter and row-sequencing controller for a (de)quantizer.
//
// Flow: on start (IDLE only) the block configuration is captured and qp is
// clamped to 51. DIV then derives qp/6 and qp%6 by repeated subtraction,
// one step per cycle. On DIV exit it registers the quant or dequant
// parameters. RUN accepts one row tag per cycle from upstream and forwards
// it to the datapath. DONE lasts one cycle and returns to IDLE.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// Upstream: row_valid/row_ready. Downstream: out_valid/out_ready.
// While out_valid is high and out_ready is low, the issued tag
// (row_idx, row_last) holds, and no new row is accepted.
//
// Ports:
//   clk, rst (async, active-low)
//   start, qp[5:0], size[1:0], slice_type, inverse : block request/config
//   row_valid / row_ready                          : upstream row handshake
//   out_valid, row_idx[4:0], row_last / out_ready  : issued row tag
//   q_scale[15:0] s, offset[27:0] s, shift[4:0]    : quant parameters
//   qp_per[3:0], qp_rem[2:0]                       : qp/6, qp%6
//   busy, done                                     : status
//   state_dbg[1:0]                                 : current FSM state
module quant_ctrl (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [5:0]         qp,
    input  logic [1:0]         size,
    input  logic               slice_type,
    input  logic               inverse,
    input  logic               row_valid,
    output logic               row_ready,
    output logic               out_valid,
    output logic [4:0]         row_idx,
    output logic               row_last,
    input  logic               out_ready,
    output logic signed [15:0] q_scale,
    output logic signed [27:0] offset,
    output logic [4:0]         shift,
    output logic [3:0]         qp_per,
    output logic [2:0]         qp_rem,
    output logic               busy,
    output logic               done,
    output logic [1:0]         state_dbg
);
    typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, RUN = 2'd2, DONE = 2'd3} state_e;

    state_e             state_q, state_d;
    logic [5:0]         rem_q, rem_d;
    logic [3:0]         per_q, per_d;
    logic [1:0]         size_q, size_d;
    logic               slice_q, slice_d;
    logic               inv_q, inv_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               all_issued_q, all_issued_d;
    logic               out_valid_q, out_valid_d;
    logic [4:0]         row_idx_q, row_idx_d;
    logic               row_last_q, row_last_d;
    logic signed [15:0] q_scale_q, q_scale_d;
    logic signed [27:0] offset_q, offset_d;
    logic [4:0]         shift_q, shift_d;
    logic [3:0]         qp_per_q, qp_per_d;
    logic [2:0]         qp_rem_q, qp_rem_d;

    logic [1:0]  k;
    logic [4:0]  fwd_amt;
    logic [15:0] fwd_scale;
    logic [15:0] inv_base;
    logic [27:0] round_base;
    logic [4:0]  last_idx;
    logic        cnt_is_last;
    logic        accept;
    logic        drain;

    // 4<<size is 32 for size=3; computed in 6 bits so N-1 lands on 31.
    assign last_idx    = 5'((6'd4 << size_q) - 6'd1);
    assign cnt_is_last = (cnt_q == last_idx);

    assign row_ready = (state_q == RUN) && !all_issued_q && (!out_valid_q || out_ready);
    assign accept    = row_valid && row_ready;
    assign drain     = out_valid_q && out_ready;

    always_comb begin
        k          = 2'd3 - size_q;
        fwd_amt    = 5'd7 + {3'b000, k} + {1'b0, per_q};
        round_base = slice_q ? 28'd85 : 28'd171;
        case (rem_q[2:0])
            3'd0:    begin fwd_scale = 16'd26214; inv_base = 16'd40; end
            3'd1:    begin fwd_scale = 16'd23302; inv_base = 16'd45; end
            3'd2:    begin fwd_scale = 16'd20560; inv_base = 16'd51; end
            3'd3:    begin fwd_scale = 16'd18396; inv_base = 16'd57; end
            3'd4:    begin fwd_scale = 16'd16384; inv_base = 16'd64; end
            3'd5:    begin fwd_scale = 16'd14564; inv_base = 16'd72; end
            default: begin fwd_scale = 16'd0;     inv_base = 16'd0;  end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        per_d        = per_q;
        size_d       = size_q;
        slice_d      = slice_q;
        inv_d        = inv_q;
        cnt_d        = cnt_q;
        all_issued_d = all_issued_q;
        out_valid_d  = out_valid_q;
        row_idx_d    = row_idx_q;
        row_last_d   = row_last_q;
        q_scale_d    = q_scale_q;
        offset_d     = offset_q;
        shift_d      = shift_q;
        qp_per_d     = qp_per_q;
        qp_rem_d     = qp_rem_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = DIV;
                    rem_d        = (qp > 6'd51) ? 6'd51 : qp;
                    per_d        = 4'd0;
                    size_d       = size;
                    slice_d      = slice_type;
                    inv_d        = inverse;
                    cnt_d        = 5'd0;
                    all_issued_d = 1'b0;
                end
            end
            DIV: begin
                if (rem_q >= 6'd6) begin
                    rem_d = rem_q - 6'd6;
                    per_d = per_q + 4'd1;
                end else begin
                    // Published parameters change only here, so they stay
                    // stable through RUN, DONE and the following IDLE.
                    qp_per_d = per_q;
                    qp_rem_d = rem_q[2:0];
                    if (inv_q) begin
                        shift_d   = {3'b000, size_q} + 5'd1;
                        offset_d  = 28'd1 << size_q;
                        q_scale_d = inv_base << per_q;
                    end else begin
                        shift_d   = 5'd16 + {3'b000, k} + {1'b0, per_q};
                        offset_d  = round_base << fwd_amt;
                        q_scale_d = fwd_scale;
                    end
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    row_idx_d   = cnt_q;
                    row_last_d  = cnt_is_last;
                    // cnt parks at N-1; all_issued blocks further accepts.
                    if (cnt_is_last) all_issued_d = 1'b1;
                    else             cnt_d        = cnt_q + 5'd1;
                end else if (drain) begin
                    out_valid_d = 1'b0;
                end
                if (drain && row_last_q) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            rem_q        <= '0;
            per_q        <= '0;
            size_q       <= '0;
            slice_q      <= 1'b0;
            inv_q        <= 1'b0;
            cnt_q        <= '0;
            all_issued_q <= 1'b0;
            out_valid_q  <= 1'b0;
            row_idx_q    <= '0;
            row_last_q   <= 1'b0;
            q_scale_q    <= '0;
            offset_q     <= '0;
            shift_q      <= '0;
            qp_per_q     <= '0;
            qp_rem_q     <= '0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            per_q        <= per_d;
            size_q       <= size_d;
            slice_q      <= slice_d;
            inv_q        <= inv_d;
            cnt_q        <= cnt_d;
            all_issued_q <= all_issued_d;
            out_valid_q  <= out_valid_d;
            row_idx_q    <= row_idx_d;
            row_last_q   <= row_last_d;
            q_scale_q    <= q_scale_d;
            offset_q     <= offset_d;
            shift_q      <= shift_d;
            qp_per_q     <= qp_per_d;
            qp_rem_q     <= qp_rem_d;
        end
    end

    assign out_valid = out_valid_q;
    assign row_idx   = row_idx_q;
    assign row_last  = row_last_q;
    assign q_scale   = q_scale_q;
    assign offset    = offset_q;
    assign shift     = shift_q;
    assign qp_per    = qp_per_q;
    assign qp_rem    = qp_rem_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign state_dbg = state_q;
endmodule

// File: tb/tb_quant_ctrl.sv
// Testbench for quant_ctrl: directed and randomized blocks checked against
// an arithmetic reference model of the parameters and the row-tag order.
module tb_quant_ctrl;
    logic               clk;
    logic               rst;
    logic               start;
    logic [5:0]         qp;
    logic [1:0]         size;
    logic               slice_type;
    logic               inverse;
    logic               row_valid;
    logic               row_ready;
    logic               out_valid;
    logic [4:0]         row_idx;
    logic               row_last;
    logic               out_ready;
    logic signed [15:0] q_scale;
    logic signed [27:0] offset;
    logic [4:0]         shift;
    logic [3:0]         qp_per;
    logic [2:0]         qp_rem;
    logic               busy;
    logic               done;
    logic [1:0]         state_dbg;

    int checks = 0;
    int errors = 0;

    int fwd_tab[6] = '{26214, 23302, 20560, 18396, 16384, 14564};
    int inv_tab[6] = '{40, 45, 51, 57, 64, 72};

    quant_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .qp         (qp),
        .size       (size),
        .slice_type (slice_type),
        .inverse    (inverse),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .out_valid  (out_valid),
        .row_idx    (row_idx),
        .row_last   (row_last),
        .out_ready  (out_ready),
        .q_scale    (q_scale),
        .offset     (offset),
        .shift      (shift),
        .qp_per     (qp_per),
        .qp_rem     (qp_rem),
        .busy       (busy),
        .done       (done),
        .state_dbg  (state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_row_ready"}, 32'(row_ready), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_row_idx"},   32'(row_idx),   0);
        chk({tag, "_row_last"},  32'(row_last),  0);
        chk({tag, "_q_scale"},   32'(q_scale),   0);
        chk({tag, "_offset"},    32'(offset),    0);
        chk({tag, "_shift"},     32'(shift),     0);
        chk({tag, "_qp_per"},    32'(qp_per),    0);
        chk({tag, "_qp_rem"},    32'(qp_rem),    0);
        chk({tag, "_busy"},      32'(busy),      0);
        chk({tag, "_done"},      32'(done),      0);
    endtask

    // Reference model: parameters straight from the arithmetic rules.
    task automatic model(input int qp_i, input int sz, input int st, input int inv,
                         output int per, output int rem, output int sh,
                         output int off, output int qs);
        int q;
        int k;
        q   = (qp_i > 51) ? 51 : qp_i;
        per = q / 6;
        rem = q % 6;
        k   = 3 - sz;
        if (inv == 0) begin
            sh  = 16 + k + per;
            off = (st != 0 ? 85 : 171) << (7 + k + per);
            qs  = fwd_tab[rem];
        end else begin
            sh  = sz + 1;
            off = 1 << sz;
            qs  = inv_tab[rem] << per;
        end
    endtask

    task automatic check_params(input string tag, input int qp_i, input int sz,
                                input int st, input int inv);
        int per, rem, sh, off, qs;
        model(qp_i, sz, st, inv, per, rem, sh, off, qs);
        chk({tag, "_qp_per"},  32'(qp_per),  per);
        chk({tag, "_qp_rem"},  32'(qp_rem),  rem);
        chk({tag, "_shift"},   32'(shift),   sh);
        chk({tag, "_offset"},  32'(offset),  off);
        chk({tag, "_q_scale"}, 32'(q_scale), qs);
    endtask

    // Driver: issue start, then count cycles until RUN opens row_ready.
    // Ends at the negedge of the first RUN cycle.
    task automatic start_block(input int qp_i, input int sz, input int st,
                               input int inv, output int div_cyc);
        @(posedge clk); #1;
        start = 1'b1; qp = 6'(qp_i); size = 2'(sz);
        slice_type = 1'(st); inverse = 1'(inv);
        row_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        div_cyc = 0;
        while (div_cyc < 20) begin
            @(negedge clk);
            if (row_ready) break;
            chk("div_busy", 32'(busy), 1);
            div_cyc++;
            @(posedge clk); #1;
        end
    endtask

    // Row streaming with scoreboard of expected tags.
    // mode 0: always valid/ready; 1: random; 2: 5-cycle downstream stall.
    task automatic stream_block(input int n, input int mode, input int abort_at,
                                input bit poke_start);
        logic [4:0] exp_q[$];
        int cyc = 0;
        int next_idx = 0;
        int stall_cnt = 0;
        int done_phase = 0;
        for (int i = 0; i < n; i++) exp_q.push_back(5'(i));
        while (cyc < 600) begin
            @(posedge clk); #1;
            case (mode)
                0: begin row_valid = 1'b1; out_ready = 1'b1; end
                1: begin
                    row_valid = 1'($urandom_range(0, 1));
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                default: begin
                    row_valid = 1'b1;
                    out_ready = !(cyc >= 4 && cyc < 9);
                end
            endcase
            start = poke_start && (cyc == 3);
            if (start) begin qp = 6'd0; size = 2'd0; end
            cyc++;
            @(negedge clk);
            if (abort_at >= 0 && next_idx == abort_at) begin
                rst = 1'b0;
                #1;
                check_zero("abort");
                start = 1'b0; row_valid = 1'b0;
                return;
            end
            if (done_phase == 1) begin
                chk("done_pulse", 32'(done), 1);
                chk("done_busy", 32'(busy), 1);
                chk("done_out_valid", 32'(out_valid), 0);
                done_phase = 2;
                continue;
            end
            if (done_phase == 2) begin
                chk("done_cleared", 32'(done), 0);
                chk("idle_busy", 32'(busy), 0);
                break;
            end
            chk("done_low", 32'(done), 0);
            if (mode == 0 && next_idx > 0) chk("back_to_back", 32'(out_valid), 1);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("extra_row", 32'(row_idx), 32'hFFFF_FFFF);
                end else begin
                    chk("row_idx", 32'(row_idx), 32'(exp_q[0]));
                    chk("row_last", 32'(row_last), 32'(next_idx == n - 1));
                end
                if (!out_ready) begin
                    chk("stall_row_ready", 32'(row_ready), 0);
                    stall_cnt++;
                end else begin
                    if (next_idx == n - 1) done_phase = 1;
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    next_idx++;
                end
            end
        end
        chk("rows_drained", next_idx, n);
        chk("done_reached", done_phase, 2);
        if (mode == 2) chk("stall_cycles", stall_cnt, 5);
    endtask

    task automatic run_block(input int qp_i, input int sz, input int st, input int inv,
                             input int mode, input int abort_at, input bit poke_start);
        int per, rem, sh, off, qs;
        int div_cyc;
        model(qp_i, sz, st, inv, per, rem, sh, off, qs);
        start_block(qp_i, sz, st, inv, div_cyc);
        chk("div_cycles", div_cyc, per + 1);
        check_params("run_entry", qp_i, sz, st, inv);
        stream_block(4 << sz, mode, abort_at, poke_start);
        if (abort_at < 0) check_params("after_done", qp_i, sz, st, inv);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; qp = '0; size = '0; slice_type = 1'b0;
        inverse = 1'b0; row_valid = 1'b0; out_ready = 1'b0;
        #3;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // qp=22 forward, 4x4 intra
        run_block(22, 0, 0, 0, 0, -1, 1'b0);
        chk("ex1_shift", 32'(shift), 22);
        chk("ex1_offset", 32'(offset), 1400832);
        chk("ex1_q_scale", 32'(q_scale), 16384);
        chk("ex1_per", 32'(qp_per), 3);
        chk("ex1_rem", 32'(qp_rem), 4);

        // qp=51 inverse, 32x32
        run_block(51, 3, 0, 1, 0, -1, 1'b0);
        chk("ex2_shift", 32'(shift), 4);
        chk("ex2_offset", 32'(offset), 8);
        chk("ex2_q_scale", 32'(q_scale), 14592);
        chk("ex2_per", 32'(qp_per), 8);

        // 8x8, continuous flow
        run_block(30, 1, 1, 0, 0, -1, 1'b0);

        // 8x8 with a 5-cycle downstream stall
        run_block(17, 1, 0, 1, 2, -1, 1'b0);

        // qp=63 clamps to 51; start during RUN ignored
        run_block(63, 2, 1, 0, 1, -1, 1'b1);
        chk("clamp_shift", 32'(shift), 25);
        chk("clamp_offset", 32'(offset), 5570560);
        chk("clamp_q_scale", 32'(q_scale), 18396);

        // reset mid-RUN at row 5, then a fresh qp=0 block
        run_block(40, 3, 0, 0, 0, 5, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("post_reset_busy", 32'(busy), 0);
        run_block(0, 0, 0, 0, 0, -1, 1'b0);

        // randomized blocks
        for (int b = 0; b < 8; b++) begin
            run_block(int'($urandom_range(0, 63)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                      1, -1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
